// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: reset PC default, NOP encoding,
// and the occupancy-width helper used by the top level and the prefetch FIFO.
package fetch_unit_pkg;

    localparam int unsigned RESET_PC_DEFAULT = 0;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs.
// Flush takes priority over push and pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             head,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OW'(1);
                2'b01:   count_d = count_q - OW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head      = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a 1-cycle-latency
// instruction memory, buffers returns in a prefetch FIFO and handles redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_data,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_WIDTH-1:0]       instr,
    output logic [PC_WIDTH-1:0]          instr_pc,
    output logic [PC_WIDTH-1:0]          instr_pc_plus1,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int unsigned OW = occ_width(DEPTH);
    localparam int unsigned FW = OW + 1;
    localparam int unsigned EW = INSTR_WIDTH + PC_WIDTH;
    localparam logic [PC_WIDTH-1:0]    RESET_PC_L = PC_WIDTH'(RESET_PC);
    localparam logic [INSTR_WIDTH-1:0] NOP_L      = INSTR_WIDTH'(NOP_INSTR);
    localparam logic [FW-1:0]          DEPTH_L    = FW'(DEPTH);

    logic [PC_WIDTH-1:0]    fpc_q, fpc_d;
    logic                   inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]    issued_pc_q, issued_pc_d;

    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic [FW-1:0]          fill;
    logic [EW-1:0]          head;
    logic [OW-1:0]          occ;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [INSTR_WIDTH-1:0] head_instr;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({issued_pc_q, imem_data}),
        .head      (head),
        .occupancy (occ)
    );

    assign {head_pc, head_instr} = head;

    always_comb begin
        // Counting the in-flight return against capacity guarantees it always has a slot.
        fill        = FW'(occ) + FW'(inflight_q);
        issue       = !rst && !redirect_valid && (fill < DEPTH_L);
        flush       = redirect_valid;
        push        = inflight_q && !redirect_valid && !rst;
        instr_valid = !rst && (occ != '0);
        pop         = instr_valid && instr_ready && !redirect_valid;

        fpc_d       = fpc_q;
        if (redirect_valid) begin
            fpc_d = redirect_pc;
        end else if (issue) begin
            fpc_d = fpc_q + PC_WIDTH'(1);
        end
        inflight_d  = issue;
        issued_pc_d = issue ? fpc_q : issued_pc_q;

        imem_req       = issue;
        imem_addr      = fpc_q;
        instr          = instr_valid ? head_instr : NOP_L;
        instr_pc       = head_pc;
        instr_pc_plus1 = head_pc + PC_WIDTH'(1);
        occupancy      = occ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q       <= RESET_PC_L;
            inflight_q  <= 1'b0;
            issued_pc_q <= '0;
        end else begin
            fpc_q       <= fpc_d;
            inflight_q  <= inflight_d;
            issued_pc_q <= issued_pc_d;
        end
    end

endmodule
